// File: rtl/dmem_arbiter.sv
// Data-memory sequencer/arbiter: MEM-stage load/store vs. word loader port,
// req/ack handshake, big-endian lane steering. Define DMEM_ARB_RR_EN for round-robin ties.
module dmem_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_req,
  input  logic        mem_wr,
  input  logic [1:0]  mem_dsize,
  input  logic        mem_loadext,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        done_mem,
  output logic        mem_misalign,
  output logic        stall,
  input  logic        ld_req,
  input  logic        ld_wr,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_wdata,
  output logic [31:0] ld_rdata,
  output logic        ld_done,
  output logic        dm_req,
  output logic        dm_wr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata,
  input  logic        dm_ack
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
  typedef enum logic {OWN_MEM, OWN_LD} own_t;

  state_t      state_q, state_d;
  own_t        own_q, own_d;
  logic        wr_q, ext_q, mis_q;
  logic [3:0]  be_q;
  logic [31:0] addr_q, wdata_q, mrdata_q, lrdata_q;
  logic [1:0]  size_q, lane_q;

  logic        any_req, grant_ld, mis_now;
  logic [3:0]  be_mem;
  logic [31:0] wd_mem, cmd_addr, ld_ext;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign any_req = mem_req | ld_req;

`ifdef DMEM_ARB_RR_EN
  own_t last_q;
  assign grant_ld = ld_req & (~mem_req | (last_q == OWN_MEM));
`else
  assign grant_ld = ld_req & ~mem_req;
`endif

  assign cmd_addr = grant_ld ? ld_addr : mem_addr;
  assign mis_now  = ((mem_dsize == 2'b01) & mem_addr[0]) | (mem_dsize[1] & (|mem_addr[1:0]));

  always_comb begin
    be_mem = 4'b1111;
    wd_mem = mem_wdata;
    case (mem_dsize)
      2'b00: begin
        be_mem = 4'b1000 >> mem_addr[1:0];
        wd_mem = {4{mem_wdata[7:0]}};
      end
      2'b01: begin
        be_mem = mem_addr[1] ? 4'b0011 : 4'b1100;
        wd_mem = {2{mem_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Big-endian: lane 0 lives in bits [31:24]
  always_comb begin
    case (lane_q)
      2'd0:    byte_sel = dm_rdata[31:24];
      2'd1:    byte_sel = dm_rdata[23:16];
      2'd2:    byte_sel = dm_rdata[15:8];
      default: byte_sel = dm_rdata[7:0];
    endcase
    half_sel = lane_q[1] ? dm_rdata[15:0] : dm_rdata[31:16];
    case (size_q)
      2'b00:   ld_ext = {{24{ext_q & byte_sel[7]}}, byte_sel};
      2'b01:   ld_ext = {{16{ext_q & half_sel[15]}}, half_sel};
      default: ld_ext = dm_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    own_d   = own_q;
    case (state_q)
      S_IDLE: if (any_req) begin
        own_d   = grant_ld ? OWN_LD : OWN_MEM;
        state_d = (!grant_ld && mis_now) ? S_DONE : S_BUSY;
      end
      S_BUSY: if (dm_ack) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      own_q    <= OWN_MEM;
      wr_q     <= 1'b0;
      be_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      size_q   <= '0;
      lane_q   <= '0;
      ext_q    <= 1'b0;
      mis_q    <= 1'b0;
      mrdata_q <= '0;
      lrdata_q <= '0;
`ifdef DMEM_ARB_RR_EN
      last_q   <= OWN_LD;
`endif
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
      if (state_q == S_IDLE && any_req) begin
        addr_q <= {cmd_addr[31:2], 2'b00};
        lane_q <= cmd_addr[1:0];
`ifdef DMEM_ARB_RR_EN
        last_q <= own_d;
`endif
        if (grant_ld) begin
          wr_q    <= ld_wr;
          be_q    <= '1;
          wdata_q <= ld_wdata;
          size_q  <= 2'b10;
          ext_q   <= 1'b0;
          mis_q   <= 1'b0;
        end else begin
          wr_q    <= mem_wr;
          be_q    <= be_mem;
          wdata_q <= wd_mem;
          size_q  <= mem_dsize;
          ext_q   <= mem_loadext;
          mis_q   <= mis_now;
          if (mis_now) mrdata_q <= '0;
        end
      end
      if (state_q == S_BUSY && dm_ack) begin
        if (own_q == OWN_MEM) mrdata_q <= ld_ext;
        else                  lrdata_q <= dm_rdata;
      end
    end
  end

  assign dm_req       = (state_q == S_BUSY);
  assign dm_wr        = wr_q;
  assign dm_be        = be_q;
  assign dm_addr      = addr_q;
  assign dm_wdata     = wdata_q;
  assign done_mem     = (state_q == S_DONE) && (own_q == OWN_MEM);
  assign ld_done      = (state_q == S_DONE) && (own_q == OWN_LD);
  assign mem_misalign = done_mem & mis_q;
  assign mem_rdata    = mrdata_q;
  assign ld_rdata     = lrdata_q;
  assign stall        = mem_req & ~done_mem;

endmodule
